pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipe_ctrl_step_sync.sv | 28 ++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and the per-cycle advance decode for the pipeline controller.
// Parameter limits live here so every file agrees on the legal ranges.
package pipe_ctrl_pkg;

    localparam int NSTAGE_MIN  = 3;
    localparam int NSTAGE_MAX  = 8;
    localparam int TIMEOUT_MIN = 1;
    localparam int TIMEOUT_MAX = 65535;
    localparam int IF_STAGE    = 0;
    localparam int CNT_W       = 32;
    localparam int WAIT_W      = 16;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_REDIRECT,
        MODE_FREEZE
    } adv_mode_e;

    // A stall outranks a redirect: the redirect is simply dropped that cycle.
    function automatic adv_mode_e decode_mode(input logic freeze,
                                              input logic stall_req,
                                              input logic redirect);
        if (freeze)
            return MODE_FREEZE;
        else if (stall_req)
            return MODE_STALL;
        else if (redirect)
            return MODE_REDIRECT;
        else
            return MODE_RUN;
    endfunction

endpackage

// File: rtl/pipe_ctrl_step_sync.sv
// Two-flop synchroniser for the debug step button plus a rising-edge detector
// producing a single-cycle step pulse.
module step_sync (
    input  logic clk,
    input  logic rst,
    input  logic debug_step,
    output logic step_pulse
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= debug_step;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign step_pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: per-stage load enables and bubble inserts for
// load-use stalls, branch redirects, memory wait, single-step debug and timeout.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE    = 5,
    parameter int HAZ_STAGE = 1,
    parameter int BR_STAGE  = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_req,
    input  logic              redirect,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              debug_en,
    input  logic              debug_step,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] stage_flush,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              err_timeout
);

    logic              step_pulse;
    logic              mem_wait;
    logic              freeze;
    adv_mode_e         mode;
    logic [WAIT_W-1:0] wait_cnt;
    logic [NSTAGE-1:0] valid_in;

    step_sync u_step_sync (
        .clk        (clk),
        .rst        (rst),
        .debug_step (debug_step),
        .step_pulse (step_pulse)
    );

    assign mem_wait = mem_req & ~mem_ack;
    assign freeze   = mem_wait | (debug_en & ~step_pulse) | err_timeout;
    assign mode     = decode_mode(freeze, stall_req, redirect);

    // Stage 0 always fetches a real instruction; others inherit from below.
    assign valid_in = {stage_valid[NSTAGE-2:0], 1'b1};

    always_comb begin
        stage_en    = '0;
        stage_flush = '0;
        if (!rst) begin
            stage_flush = '1;
        end else begin
            case (mode)
                MODE_STALL: begin
                    for (int i = 0; i < NSTAGE; i++) begin
                        stage_en[i]    = (i > HAZ_STAGE);
                        stage_flush[i] = (i == HAZ_STAGE + 1);
                    end
                end
                MODE_REDIRECT: begin
                    stage_en = '1;
                    for (int i = 0; i < NSTAGE; i++)
                        stage_flush[i] = (i > IF_STAGE) && (i <= BR_STAGE);
                end
                MODE_RUN: stage_en = '1;
                default: begin
                    stage_en    = '0;
                    stage_flush = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= '0;
        end else begin
            for (int i = 0; i < NSTAGE; i++)
                if (stage_en[i])
                    stage_valid[i] <= stage_flush[i] ? 1'b0 : valid_in[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mode == MODE_STALL)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mode == MODE_REDIRECT)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // The wait counter saturates at TIMEOUT; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (mem_wait) begin
            if (wait_cnt != WAIT_W'(TIMEOUT))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_W'(TIMEOUT - 1))
                err_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule
